data_mem: RTL and testbench
===========================

# data_mem

Parametrised data memory for the RV32I core, the successor to the fixed 4 KiB word RAM.
- Adds byte/halfword/word access with load sign/zero extension and byte-lane write strobes.
- Adds a valid/ready request channel, a registered read response and a programmable number of wait states.
- Sits between the core's MEM stage and a block-RAM array of configurable depth.

## Interface
Parameters:
- ADDR_W, 10, word-address bits; depth = 2**ADDR_W words (default 4 KiB).
- WAIT_CYCLES, 0, extra stall cycles per access (0..15).
- INIT_FILE, "", hex image loaded with $readmemh at elaboration if non-empty.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at rising clk.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_unsigned  in  1  load zero-extends when 1 (lbu/lhu).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (rs2).
- rsp_valid  out  1  one-cycle response strobe, for loads and stores.
- rsp_rdata  out  32  extended load data; 0 for stores.
- rsp_err  out  1  access fault, qualified by rsp_valid.

## Operation
- Request fields are captured on acceptance.
- Array index is addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo depth.
- Stores:
  - byte: strobe 1<<addr[1:0], data replicated on all four lanes.
  - halfword: strobe 0011 or 1100 by addr[1], data replicated on both halves.
  - word: strobe 1111.
  - Only strobed bytes change.
- Loads:
  - Select the lane by addr[1:0].
  - Sign-extend bit 7 (byte) or bit 15 (halfword) unless req_unsigned.
  - Word loads ignore req_unsigned.
- State machine:
  - IDLE: req_ready=1. On acceptance, go to ACCESS if WAIT_CYCLES==0, else go to WAIT with counter=WAIT_CYCLES-1.
  - WAIT: req_ready=0. Counter decrements each cycle; at 0, go to ACCESS.
  - ACCESS: array write/read occurs; rsp_* registered; state returns to IDLE on the same edge.
  - With WAIT_CYCLES==0, ACCESS coincides with the acceptance edge, so the block can accept a request every cycle.
- Memory contents are not reset.

## Timing
- Reset values:
  - state=IDLE, counter=0
  - rsp_valid=0, rsp_rdata=0, rsp_err=0
  - req_ready=1 once rst deasserts
- Latency:
  - Acceptance at edge E0; rsp_valid is high in the cycle after edge E0+WAIT_CYCLES.
  - Store commits at edge E0+WAIT_CYCLES.
- rsp_valid is high for exactly one cycle per accepted request. There is no backpressure on the response.
- Read-after-write, WAIT_CYCLES=0, same word on consecutive cycles: the load returns the new data. The array write and read of adjacent requests occur on different edges.
- Requests presented while req_ready=0 are ignored. The requester must hold them stable until accepted.
- rst asserted mid-WAIT: the pending request is dropped, a pending store is not committed, and no response is issued.

## Configuration
- DMEM_MISALIGN_CHECK_EN defined:
  - A halfword with addr[0]=1, a word with addr[1:0]!=0, or req_size=11 produces rsp_err=1 and rsp_rdata=0.
  - No array write occurs.
  - Latency is unchanged.
- Undefined:
  - rsp_err is tied 0.
  - req_size=11 is treated as word.
  - Misaligned addresses are aligned down: addr[0] is cleared for halfwords, addr[1:0] for words.

## Structure
- Package dmem_pkg holds:
  - size encodings SIZE_B/SIZE_H/SIZE_W/SIZE_RSV
  - state enum {IDLE, WAIT, ACCESS}
  - WAIT counter width constant (4)
- One sub-module, dmem_lane_fmt (combinational): computes store strobes, store data replication, load extraction and extension.
- The top level holds the FSM, the counter, the request register and the array.

## Test plan
- WAIT_CYCLES=0: sw 0xDEADBEEF to 0x100, then lw from 0x100 -> rsp_valid high for one cycle, rsp_rdata=0xDEADBEEF; req_ready constantly 1.
- Sub-word loads after that store:
  - lb 0x103 -> 0xFFFFFFDE
  - lbu 0x103 -> 0x000000DE
  - lh 0x100 -> 0xFFFFBEEF
  - lhu 0x102 -> 0x0000DEAD
- sb 0x55 to 0x101 over 0xDEADBEEF, then lw 0x100 -> 0xDEAD55EF.
- WAIT_CYCLES=3: accept at E0 -> req_ready low for 3 cycles; rsp_valid in the cycle after E0+3; a second request held during the stall is accepted only once req_ready returns.
- DMEM_MISALIGN_CHECK_EN: sw to 0x102 -> rsp_err=1 and word 0x100 unchanged. Without the macro, the same store writes word 0x100.
- rst asserted during WAIT of a sw -> no rsp_valid and the target word is unchanged; after rst deasserts, all outputs are 0 and req_ready=1.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg -- shared definitions for the data_mem block.
//   Access size encodings carried on req_size, the request state machine
//   states, and the width of the wait-state counter.
package dmem_pkg;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS
  } state_e;

  // Holds WAIT_CYCLES-1 for WAIT_CYCLES up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_lane_fmt.sv
// dmem_lane_fmt -- combinational byte-lane formatter for data_mem.
//   Turns one request (size, signedness, low address bits, store data) and the
//   addressed memory word into byte-write strobes, lane-replicated store data
//   and the extended load result.
//
// Configuration macro: DMEM_MISALIGN_CHECK_EN
//   defined   : misaligned halfword/word or reserved size raises err, suppresses
//               strobes and forces rdata to 0.
//   undefined : err is 0, the reserved size acts as word and misaligned
//               addresses are aligned down.
//
// Ports:
//   size        in   2  access size (SIZE_B/SIZE_H/SIZE_W/SIZE_RSV)
//   is_unsigned in   1  zero-extend sub-word loads when 1
//   addr_lo     in   2  byte offset within the word
//   wdata       in  32  right-aligned store data
//   rword       in  32  current contents of the addressed word
//   wstrb       out  4  byte-write strobes
//   wdata_rep   out 32  store data replicated onto the strobed lanes
//   rdata       out 32  extended load data
//   err         out  1  access fault
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata,
  output logic        err
);

  logic [1:0]  eff_size;
  logic [1:0]  eff_addr;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    eff_size = size;
    eff_addr = addr_lo;
    err      = 1'b0;
`ifdef DMEM_MISALIGN_CHECK_EN
    case (size)
      SIZE_H:   err = addr_lo[0];
      SIZE_W:   err = |addr_lo;
      SIZE_RSV: err = 1'b1;
      default:  err = 1'b0;
    endcase
`else
    // Reserved size degrades to a word; misaligned offsets are rounded down.
    if (size == SIZE_RSV) begin
      eff_size = SIZE_W;
    end
    if (eff_size == SIZE_H) begin
      eff_addr[0] = 1'b0;
    end else if (eff_size == SIZE_W) begin
      eff_addr = 2'b00;
    end
`endif

    byte_sel = rword[{eff_addr, 3'b000} +: 8];
    half_sel = rword[{eff_addr[1], 4'b0000} +: 16];

    case (eff_size)
      SIZE_B: begin
        wstrb     = 4'b0001 << eff_addr;
        wdata_rep = {4{wdata[7:0]}};
        rdata     = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SIZE_H: begin
        wstrb     = eff_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata     = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      default: begin
        wstrb     = 4'b1111;
        wdata_rep = wdata;
        rdata     = rword;
      end
    endcase

    // A faulting access must neither write nor return data.
    if (err) begin
      wstrb = 4'b0000;
      rdata = 32'h0;
    end
  end

endmodule

// File: rtl/data_mem.sv
// data_mem -- RV32I data memory with byte/halfword/word access, a valid/ready
//   request channel, a registered one-cycle response strobe and a
//   programmable number of wait states in front of a word-wide array.
//
// Configuration macro: DMEM_MISALIGN_CHECK_EN (see dmem_lane_fmt) enables
//   access-fault reporting on rsp_err; without it rsp_err stays 0.
//
// Parameters:
//   ADDR_W      word-address bits, depth = 2**ADDR_W words
//   WAIT_CYCLES extra stall cycles per access (0..15)
//   INIT_FILE   preload image name for the array
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   req_valid     in   request present
//   req_ready     out  request accepted when req_valid && req_ready at clk
//   req_we        in   1 = store, 0 = load
//   req_size      in   access size
//   req_unsigned  in   zero-extend sub-word loads
//   req_addr      in   byte address (upper bits ignored, wraps mod depth)
//   req_wdata     in   right-aligned store data
//   rsp_valid     out  one-cycle response strobe
//   rsp_rdata     out  extended load data, 0 for stores
//   rsp_err       out  access fault, qualified by rsp_valid
module data_mem
  import dmem_pkg::*;
#(
  parameter int    ADDR_W      = 10,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  logic [31:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              accept;
  logic              use_in;
  logic              do_access;
  logic              a_we;
  logic [1:0]        a_size;
  logic              a_uns;
  logic [ADDR_W+1:0] a_addr;
  logic [31:0]       a_wdata;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       rword;
  logic [3:0]        fmt_wstrb;
  logic [31:0]       fmt_wdata;
  logic [31:0]       fmt_rdata;
  logic              fmt_err;
  logic              unused_addr_hi;

  // Address bits above the array are deliberately ignored (wrap-around).
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  // With no wait states the access happens on the acceptance edge, so the
  // live request feeds the array; otherwise the captured copy does.
  assign use_in  = (state_q == IDLE);
  assign a_we    = use_in ? req_we               : we_q;
  assign a_size  = use_in ? req_size             : size_q;
  assign a_uns   = use_in ? req_unsigned         : uns_q;
  assign a_addr  = use_in ? req_addr[ADDR_W+1:0] : addr_q;
  assign a_wdata = use_in ? req_wdata            : wdata_q;

  assign do_access = (WAIT_CYCLES == 0) ? accept : (state_q == ACCESS);

  assign idx   = a_addr[ADDR_W+1:2];
  assign rword = mem[idx];

  dmem_lane_fmt u_lane_fmt (
    .size        (a_size),
    .is_unsigned (a_uns),
    .addr_lo     (a_addr[1:0]),
    .wdata       (a_wdata),
    .rword       (rword),
    .wstrb       (fmt_wstrb),
    .wdata_rep   (fmt_wdata),
    .rdata       (fmt_rdata),
    .err         (fmt_err)
  );

  // Request FSM. The counter holds the remaining WAIT cycles; when it reaches
  // zero the next cycle is the ACCESS cycle, whose closing edge performs the
  // array operation. This places the access at acceptance edge + WAIT_CYCLES.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'h0;
    rsp_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr[ADDR_W+1:0];
          wdata_d = req_wdata;
          if (WAIT_CYCLES != 0) begin
            cnt_d   = CNT_INIT;
            state_d = (CNT_INIT == '0) ? ACCESS : WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_access) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = fmt_err;
      rsp_rdata_d = a_we ? 32'h0 : fmt_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= SIZE_B;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Array contents are never reset; writes are blocked while rst is held so a
  // request presented during reset cannot commit.
  always_ff @(posedge clk) begin
    if (do_access && a_we && !rst) begin
      for (int i = 0; i < 4; i++) begin
        if (fmt_wstrb[i]) begin
          mem[idx][8*i +: 8] <= fmt_wdata[8*i +: 8];
        end
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem -- self-checking bench for data_mem.
//   Two instances share clk/rst: dut0 with WAIT_CYCLES=0 and dut1 with
//   WAIT_CYCLES=3. Each has a byte-addressed reference memory, an expected
//   response queue filled at acceptance, and a monitor that pops on rsp_valid.
module tb_data_mem;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_we;
  logic [1:0]       req_unsigned;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_err;
  logic [1:0][1:0]  req_size;
  logic [1:0][31:0] req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0][31:0] rsp_rdata;

  data_mem #(.ADDR_W(10), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  data_mem #(.ADDR_W(10), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic [7:0] ref_mem [0:1][0:4095];
  int free_at [0:1];

  function automatic int waitOf(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Reference: 4 KiB byte-addressed memory, little-endian.
  function automatic void modelAccess(input int d, input logic we, input logic [1:0] size,
                                      input logic uns, input logic [31:0] addr,
                                      input logic [31:0] wdata,
                                      output logic [31:0] rdata, output logic err);
    int off;
    int n;
    logic [31:0] v;
    off   = int'(addr % 32'd4096);
    n     = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    err   = 1'b0;
    rdata = 32'h0;
`ifdef DMEM_MISALIGN_CHECK_EN
    if (size == 2'b11 || (off % n) != 0) begin
      err = 1'b1;
      return;
    end
`else
    off = off - (off % n);
`endif
    if (we) begin
      for (int i = 0; i < n; i++) ref_mem[d][off+i] = wdata[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(ref_mem[d][off+i]) << (8*i));
      if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      rdata = v;
    end
  endfunction

  task automatic pushExp(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Drive one request at posedge+1 and hold it until accepted. The block is
  // free again WAIT+1 edges after an acceptance, which fixes the edge on
  // which this request must be taken.
  task automatic applyStimulus(input int d, input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr,
                               input logic [31:0] wdata, input bit expect_rsp);
    int   exp_acc;
    int   acc;
    int   waited;
    logic r;
    exp_t e;
    req_valid[d]    = 1'b1;
    req_we[d]       = we;
    req_size[d]     = size;
    req_unsigned[d] = uns;
    req_addr[d]     = addr;
    req_wdata[d]    = wdata;
    exp_acc = (cyc + 1 > free_at[d]) ? cyc + 1 : free_at[d];
    waited  = 0;
    r       = 1'b0;
    while (!r && waited <= 40) begin
      @(negedge clk);
      r = req_ready[d];
      @(posedge clk);
      waited++;
    end
    #1;
    checks++;
    if (!r) begin
      errors++;
      $display("[TB] FAIL accept_timeout dut%0d: no acceptance after %0d edges, required edge %0d",
               d, waited, exp_acc);
      req_valid[d] = 1'b0;
      return;
    end
    acc = cyc;
    if (acc != exp_acc) begin
      errors++;
      $display("[TB] FAIL accept_edge dut%0d: accepted at edge %0d, required edge %0d",
               d, acc, exp_acc);
    end
    free_at[d] = acc + waitOf(d) + 1;
    if (expect_rsp) begin
      modelAccess(d, we, size, uns, addr, wdata, e.rdata, e.err);
      e.due = acc + waitOf(d);
      pushExp(d, e);
    end
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor side of the scoreboard: one expected entry per rsp_valid strobe.
  task automatic checkOutput(input int d);
    exp_t e;
    int   n;
    n = (d == 0) ? q0.size() : q1.size();
    if (rsp_valid[d]) begin
      checks++;
      if (n == 0) begin
        errors++;
        $display("[TB] FAIL rsp_unexpected dut%0d: rsp_valid=1 after edge %0d, required no response",
                 d, cyc);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        if (cyc != e.due || rsp_rdata[d] !== e.rdata || rsp_err[d] !== e.err) begin
          errors++;
          $display("[TB] FAIL rsp dut%0d: edge=%0d rdata=%08h err=%0b, required edge=%0d rdata=%08h err=%0b",
                   d, cyc, rsp_rdata[d], rsp_err[d], e.due, e.rdata, e.err);
        end
      end
    end else if (n > 0) begin
      e = (d == 0) ? q0[0] : q1[0];
      if (e.due < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL rsp_missing dut%0d: no rsp_valid after edge %0d, required rdata=%08h",
                 d, e.due, e.rdata);
        if (d == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput(0);
      checkOutput(1);
    end
  end

  task automatic checkIdle(input int d);
    checks++;
    if (rsp_valid[d] !== 1'b0 || rsp_err[d] !== 1'b0 || rsp_rdata[d] !== 32'h0 ||
        req_ready[d] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL idle_state dut%0d: valid=%0b err=%0b rdata=%08h ready=%0b, required 0 0 00000000 1",
               d, rsp_valid[d], rsp_err[d], rsp_rdata[d], req_ready[d]);
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rnd;
    logic [31:0] addr;
    int          idx;
    req_valid    = '0;
    req_we       = '0;
    req_unsigned = '0;
    req_size     = '0;
    req_addr     = '0;
    req_wdata    = '0;
    free_at[0]   = 0;
    free_at[1]   = 0;
    rst          = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkIdle(0);
    checkIdle(1);
    @(posedge clk);
    #1;

    for (int d = 0; d < 2; d++) begin
      // Known contents for words 0..79 so random loads never see X.
      for (int w = 0; w < 80; w++) applyStimulus(d, 1'b1, 2'b10, 1'b0, 32'(w*4), $urandom, 1'b1);

      // Directed sequence, back-to-back so dut0 exercises read-after-write.
      applyStimulus(d, 1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1);
      applyStimulus(d, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 1'b1);
      applyStimulus(d, 1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 1'b1);
      applyStimulus(d, 1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 1'b1);
      applyStimulus(d, 1'b0, 2'b01, 1'b0, 32'h0000_0100, 32'h0, 1'b1);
      applyStimulus(d, 1'b0, 2'b01, 1'b1, 32'h0000_0102, 32'h0, 1'b1);
      applyStimulus(d, 1'b1, 2'b00, 1'b0, 32'h0000_0101, 32'h0000_0055, 1'b1);
      applyStimulus(d, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 1'b1);
      applyStimulus(d, 1'b0, 2'b10, 1'b0, 32'hFFFF_F100, 32'h0, 1'b1);
      applyStimulus(d, 1'b1, 2'b10, 1'b0, 32'h0000_0102, 32'h1122_3344, 1'b1);
      applyStimulus(d, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 1'b1);
      applyStimulus(d, 1'b0, 2'b11, 1'b1, 32'h0000_0100, 32'h0, 1'b1);
      idle(2);

      for (int k = 0; k < 150; k++) begin
        rnd  = $urandom;
        idx  = $urandom_range(0, 79);
        addr = {rnd[31:12], 3'b000, 7'(idx), rnd[1:0]};
        applyStimulus(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), addr, $urandom, 1'b1);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle(6);
    end

    // Reset during the WAIT phase of a store: nothing commits, nothing returns.
    applyStimulus(1, 1'b1, 2'b10, 1'b0, 32'h0000_0104, 32'hCAFE_F00D, 1'b0);
    req_valid[1] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    free_at[1] = 0;
    @(negedge clk);
    checkIdle(0);
    checkIdle(1);
    @(posedge clk);
    #1;
    applyStimulus(1, 1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'h0, 1'b1);
    idle(8);

    checks++;
    if (q0.size() + q1.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d responses outstanding, required 0", q0.size() + q1.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
